// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and operand-address stage of the 6502 core. Owns the
// program counter, reads the opcode plus 0-2 operand bytes and, for the two
// indirect modes, the two zero-page pointer bytes. It then presents the
// opcode, first operand byte and effective address to the decoder.
//
// Ports
//   clk, reset_n        clock (rising edge) / asynchronous reset, active HIGH
//   mem_addr, mem_re    memory read request; one strobe cycle per byte
//   mem_rdata           read data, valid in the cycle after mem_re
//   x_in, y_in          index register values
//   pc_load,
//   pc_load_value       PC reload, taken only on the completing handshake
//   instruction         latched opcode
//   operand             first operand byte (0 for implied)
//   addr                effective address
//   pc                  address of the next byte to fetch
//   instruction_ready   outputs valid (level)
//   instruction_done    decoder completion
//   state_dbg           current FSM state, for observation only
//
// Handshake: instruction_ready rises on the edge that enters READY and stays
// high with instruction/operand/addr frozen. The transfer completes on the
// first rising edge in READY where instruction_done is 1; instruction_ready
// falls on that edge and the next opcode read is issued in the very next
// cycle. instruction_done outside READY has no effect.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [REG_WIDTH-1:0]  instruction,
    output logic [REG_WIDTH-1:0]  operand,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        OP_RQ = 4'd0,
        OP_WT = 4'd1,
        LO_RQ = 4'd2,
        LO_WT = 4'd3,
        HI_RQ = 4'd4,
        HI_WT = 4'd5,
        PL_RQ = 4'd6,
        PL_WT = 4'd7,
        PH_RQ = 4'd8,
        PH_WT = 4'd9,
        READY = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        M_IMP  = 4'd0,
        M_IMM  = 4'd1,
        M_ZPG  = 4'd2,
        M_ZPX  = 4'd3,
        M_ZPY  = 4'd4,
        M_ABS  = 4'd5,
        M_ABX  = 4'd6,
        M_ABY  = 4'd7,
        M_INDX = 4'd8,
        M_INDY = 4'd9,
        M_REL  = 4'd10
    } mode_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [REG_WIDTH-1:0]  PTR_ONE = 1;

    // Addressing mode from the bbb/cc fields, with the few opcode-specific
    // exceptions (JSR absolute, LDX/STX zp,Y and LDX abs,Y).
    function automatic mode_t decode_mode(input logic [7:0] op);
        mode_t m;
        m = M_IMP;
        case (op[4:2])
            3'b000: begin
                if (op[1:0] == 2'b01)  m = M_INDX;
                else if (op == 8'h20)  m = M_ABS;
                else if (op[7])        m = M_IMM;
                else                   m = M_IMP;
            end
            3'b001: m = M_ZPG;
            3'b010: m = (op[1:0] == 2'b01) ? M_IMM : M_IMP;
            3'b011: m = M_ABS;
            3'b100: begin
                if (op[1:0] == 2'b01)      m = M_INDY;
                else if (op[1:0] == 2'b00) m = M_REL;
                else                       m = M_IMP;
            end
            3'b101: m = (op == 8'h96 || op == 8'hB6) ? M_ZPY : M_ZPX;
            3'b110: m = (op[1:0] == 2'b01) ? M_ABY : M_IMP;
            default: m = (op == 8'hBE) ? M_ABY : M_ABX;
        endcase
        return m;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] zext(input logic [REG_WIDTH-1:0] v);
        return {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, v};
    endfunction

    // Registered state
    state_t                state_q, state_d;
    mode_t                 mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  op_q, op_d;
    logic [REG_WIDTH-1:0]  lo_q, lo_d;
    logic [REG_WIDTH-1:0]  ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]  pl_q, pl_d;

    // Combinational results
    mode_t                 rdata_mode;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  load_out;
    logic [REG_WIDTH-1:0]  out_instr;
    logic [REG_WIDTH-1:0]  out_operand;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [REG_WIDTH-1:0]  zp_x;
    logic [REG_WIDTH-1:0]  zp_y;
    logic [ADDR_WIDTH-1:0] hi_base;
    logic [ADDR_WIDTH-1:0] ptr_base;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pc_d        = pc_q;
        op_d        = op_q;
        lo_d        = lo_q;
        ptr_d       = ptr_q;
        pl_d        = pl_q;
        rd_req      = 1'b0;
        rd_addr     = pc_q;
        load_out    = 1'b0;
        out_instr   = op_q;
        out_operand = lo_q;
        out_addr    = '0;
        rdata_mode  = decode_mode(mem_rdata);
        // Page-zero sums wrap at 8 bits by construction.
        zp_x        = mem_rdata + x_in;
        zp_y        = mem_rdata + y_in;
        hi_base     = {mem_rdata, lo_q};
        ptr_base    = {mem_rdata, pl_q};

        case (state_q)
            OP_RQ: begin
                rd_req  = 1'b1;
                state_d = OP_WT;
            end
            OP_WT: begin
                op_d   = mem_rdata;
                mode_d = rdata_mode;
                pc_d   = pc_q + PC_ONE;
                if (rdata_mode == M_IMP) begin
                    state_d     = READY;
                    load_out    = 1'b1;
                    out_instr   = mem_rdata;
                    out_operand = '0;
                    out_addr    = '0;
                end else begin
                    state_d = LO_RQ;
                end
            end
            LO_RQ: begin
                rd_req  = 1'b1;
                state_d = LO_WT;
            end
            LO_WT: begin
                lo_d  = mem_rdata;
                pc_d  = pc_q + PC_ONE;
                // (ind,X) samples X here because the pointer reads depend on it.
                ptr_d = (mode_q == M_INDX) ? zp_x : mem_rdata;
                case (mode_q)
                    M_ABS, M_ABX, M_ABY: state_d = HI_RQ;
                    M_INDX, M_INDY:      state_d = PL_RQ;
                    default: begin
                        state_d     = READY;
                        load_out    = 1'b1;
                        out_operand = mem_rdata;
                        case (mode_q)
                            M_ZPG:   out_addr = zext(mem_rdata);
                            M_ZPX:   out_addr = zext(zp_x);
                            M_ZPY:   out_addr = zext(zp_y);
                            M_IMM:   out_addr = pc_q;
                            M_REL:   out_addr = pc_q + PC_ONE;
                            default: out_addr = '0;
                        endcase
                    end
                endcase
            end
            HI_RQ: begin
                rd_req  = 1'b1;
                state_d = HI_WT;
            end
            HI_WT: begin
                pc_d     = pc_q + PC_ONE;
                state_d  = READY;
                load_out = 1'b1;
                case (mode_q)
                    M_ABX:   out_addr = hi_base + zext(x_in);
                    M_ABY:   out_addr = hi_base + zext(y_in);
                    default: out_addr = hi_base;
                endcase
            end
            PL_RQ: begin
                rd_req  = 1'b1;
                rd_addr = zext(ptr_q);
                state_d = PL_WT;
            end
            PL_WT: begin
                pl_d    = mem_rdata;
                state_d = PH_RQ;
            end
            PH_RQ: begin
                rd_req  = 1'b1;
                // High pointer byte wraps within page zero.
                rd_addr = zext(ptr_q + PTR_ONE);
                state_d = PH_WT;
            end
            PH_WT: begin
                state_d  = READY;
                load_out = 1'b1;
                out_addr = (mode_q == M_INDY) ? ptr_base + zext(y_in) : ptr_base;
            end
            READY: begin
                if (instruction_done) begin
                    state_d = OP_RQ;
                    if (pc_load) pc_d = pc_load_value;
                end
            end
            default: state_d = OP_RQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q           <= OP_RQ;
            mode_q            <= M_IMP;
            pc_q              <= RESET_PC;
            op_q              <= '0;
            lo_q              <= '0;
            ptr_q             <= '0;
            pl_q              <= '0;
            instruction       <= '0;
            operand           <= '0;
            addr              <= '0;
            instruction_ready <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            ptr_q   <= ptr_d;
            pl_q    <= pl_d;
            if (load_out) begin
                instruction       <= out_instr;
                operand           <= out_operand;
                addr              <= out_addr;
                instruction_ready <= 1'b1;
            end else if (state_q == READY && instruction_done) begin
                instruction_ready <= 1'b0;
            end
        end
    end

    // The state register already sits in OP_RQ while reset is held, so the
    // read strobe is gated by reset to keep the bus idle until release.
    assign mem_re    = rd_req & ~reset_n;
    assign mem_addr  = mem_re ? rd_addr : '0;
    assign pc        = pc_q;
    assign state_dbg = state_q;

endmodule
